// File: rtl/decompressor_pack_if.sv
// Fetch-side and CPU-side handshake bundle for the packed-token decompressor.
// The master side is the decompressor. The slave side is the imem/CPU environment.
interface decompressor_pack_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_addr;
    logic [1:0]       instr_slot;
    logic             instr_valid;
    logic             instr_ready;
    logic             redirect;
    logic [WIDTH-1:0] redirect_addr;

    modport master (
        output imem_addr,
        output instr,
        output instr_addr,
        output instr_slot,
        output instr_valid,
        input  imem_rdata,
        input  instr_ready,
        input  redirect,
        input  redirect_addr
    );

    modport slave (
        input  imem_addr,
        input  instr,
        input  instr_addr,
        input  instr_slot,
        input  instr_valid,
        output imem_rdata,
        output instr_ready,
        output redirect,
        output redirect_addr
    );
endinterface

// File: rtl/decompressor_pack.sv
// Expands raw or packed-token compressed words into one instruction per cycle.
// The token table is runtime-writable and is not cleared by reset.
module decompressor_pack #(
    parameter int                   WIDTH      = 32,
    parameter logic [WIDTH-1:0]     PCADD      = 32'b100,
    parameter int                   ENCODE_LEN = 4,
    parameter logic [ENCODE_LEN-1:0] OPCODE    = 4'b1111,
    parameter int                   IDX_BITS   = 7,
    parameter int                   PACK       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    decompressor_pack_if.master  bus,
    input  logic                 wme,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 fmt_err,
    output logic [15:0]          tok_count
);
    typedef enum logic {FETCH, EXPAND} state_e;

    localparam int DEPTH = 2**IDX_BITS;
    localparam int IW = PACK*IDX_BITS;
    localparam logic [1:0] KMAX = 2'(PACK-1);

    logic [WIDTH-1:0] tbl_q [DEPTH];

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  instr_q, instr_d;
    logic [WIDTH-1:0]  iaddr_q, iaddr_d;
    logic [1:0]        oslot_q, oslot_d;
    logic              valid_q, valid_d;
    logic [1:0]        slot_q, slot_d;
    logic [IW-1:0]     hidx_q, hidx_d;
    logic [1:0]        hk_q, hk_d;
    logic              fmt_q, fmt_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]    word;
    logic                is_tok;
    logic [1:0]          w_k;
    logic                w_bad;
    logic [1:0]          w_last;
    logic                load;
    logic [15:0]         cnt_inc;
    logic [IDX_BITS-1:0] idx_a [PACK];

    always_ff @(posedge clk) begin
        if (wme) begin
            tbl_q[wr_idx] <= wr_data;
        end
    end

    for (genvar j = 0; j < PACK; j++) begin : g_idx
        assign idx_a[j] = hidx_q[j*IDX_BITS +: IDX_BITS];
    end

    assign word    = bus.imem_rdata;
    assign is_tok  = word[WIDTH-1 -: ENCODE_LEN] == OPCODE;
    assign w_k     = word[WIDTH-ENCODE_LEN-1 -: 2];
    assign w_bad   = w_k > KMAX;
    // Over-long words are clamped to PACK tokens; the stored k is the last slot.
    assign w_last  = w_bad ? KMAX : w_k;
    assign load    = !valid_q || bus.instr_ready;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        oslot_d = oslot_q;
        valid_d = valid_q;
        slot_d  = slot_q;
        hidx_d  = hidx_q;
        hk_d    = hk_q;
        fmt_d   = fmt_q;
        cnt_d   = cnt_q;
        if (bus.redirect) begin
            pc_d    = bus.redirect_addr;
            valid_d = 1'b0;
            state_d = FETCH;
            slot_d  = 2'd0;
        end else if (load) begin
            unique case (state_q)
                FETCH: begin
                    valid_d = 1'b1;
                    iaddr_d = pc_q;
                    oslot_d = 2'd0;
                    if (is_tok) begin
                        instr_d = tbl_q[word[IDX_BITS-1:0]];
                        cnt_d   = cnt_inc;
                        if (w_bad) begin
                            fmt_d = 1'b1;
                        end
                        if (w_last == 2'd0) begin
                            pc_d = pc_q + PCADD;
                        end else begin
                            hidx_d  = word[IW-1:0];
                            hk_d    = w_last;
                            slot_d  = 2'd1;
                            state_d = EXPAND;
                        end
                    end else begin
                        instr_d = word;
                        pc_d    = pc_q + PCADD;
                    end
                end
                EXPAND: begin
                    instr_d = tbl_q[idx_a[slot_q]];
                    oslot_d = slot_q;
                    cnt_d   = cnt_inc;
                    if (slot_q == hk_q) begin
                        pc_d    = pc_q + PCADD;
                        state_d = FETCH;
                        slot_d  = 2'd0;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            iaddr_q <= '0;
            oslot_q <= '0;
            valid_q <= 1'b0;
            slot_q  <= '0;
            hidx_q  <= '0;
            hk_q    <= '0;
            fmt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
            oslot_q <= oslot_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
            hidx_q  <= hidx_d;
            hk_q    <= hk_d;
            fmt_q   <= fmt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = iaddr_q;
    assign bus.instr_slot  = oslot_q;
    assign bus.instr_valid = valid_q;
    assign fmt_err         = fmt_q;
    assign tok_count       = cnt_q;
endmodule

// File: tb/tb_decompressor_pack.sv
// Directed bench for decompressor_pack: raw, packed, backpressure,
// redirect, table-write hazard and format-error cases.
module tb_decompressor_pack;
    logic        clk = 1'b0;
    logic        reset;
    logic        wme;
    logic [6:0]  wr_idx;
    logic [31:0] wr_data;
    logic        fmt_err;
    logic [15:0] tok_count;
    logic [31:0] imem [256];

    int n_chk = 0;
    int n_err = 0;

    decompressor_pack_if #(.WIDTH(32)) bus ();

    decompressor_pack dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .wme       (wme),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .fmt_err   (fmt_err),
        .tok_count (tok_count)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = imem[bus.imem_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic out(input string tag, input logic [31:0] i,
                       input logic [31:0] a, input logic [1:0] s);
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, ".instr"}, bus.instr, i);
        check({tag, ".addr"}, bus.instr_addr, a);
        check({tag, ".slot"}, 32'(bus.instr_slot), 32'(s));
    endtask

    task automatic redir(input logic [31:0] a);
        bus.redirect      = 1'b1;
        bus.redirect_addr = a;
        step();
        bus.redirect = 1'b0;
        check("redir.valid", 32'(bus.instr_valid), 32'd0);
        check("redir.pc", bus.imem_addr, a);
    endtask

    task automatic twr(input logic [6:0] i, input logic [31:0] d);
        wme = 1'b1;
        wr_idx = i;
        wr_data = d;
        step();
        wme = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'hE1A00000;
        imem[0]  = 32'hE3A00001;
        imem[1]  = 32'hE2800001;
        imem[2]  = 32'hF8008485;
        imem[4]  = 32'hF0000005;
        imem[6]  = 32'hFCE08485;
        imem[10] = 32'hE3A0202A;
        reset = 1'b1;
        wme = 1'b0;
        wr_idx = '0;
        wr_data = '0;
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        @(negedge clk);
        twr(7'd5, 32'hE3A01005);
        twr(7'd9, 32'hE0811001);
        twr(7'd2, 32'hE5801000);
        check("rst.valid", 32'(bus.instr_valid), 32'd0);
        check("rst.instr", bus.instr, 32'd0);
        check("rst.pc", bus.imem_addr, 32'd0);
        check("rst.tok", 32'(tok_count), 32'd0);
        check("rst.fmt", 32'(fmt_err), 32'd0);
        reset = 1'b0;

        step(); out("raw0", 32'hE3A00001, 32'd0, 2'd0);
        step(); out("raw1", 32'hE2800001, 32'd4, 2'd0);
        check("raw.tok", 32'(tok_count), 32'd0);
        step(); out("pk0", 32'hE3A01005, 32'd8, 2'd0);
        check("pk0.pc", bus.imem_addr, 32'd8);
        step(); out("pk1", 32'hE0811001, 32'd8, 2'd1);
        check("pk1.pc", bus.imem_addr, 32'd8);
        step(); out("pk2", 32'hE5801000, 32'd8, 2'd2);
        check("pk2.pc", bus.imem_addr, 32'd12);
        check("pk.tok", 32'(tok_count), 32'd3);

        redir(32'd8);
        step(); out("bp0", 32'hE3A01005, 32'd8, 2'd0);
        step(); out("bp1", 32'hE0811001, 32'd8, 2'd1);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            out("bp.hold", 32'hE0811001, 32'd8, 2'd1);
            check("bp.pc", bus.imem_addr, 32'd8);
        end
        bus.instr_ready = 1'b1;
        step(); out("bp2", 32'hE5801000, 32'd8, 2'd2);
        check("bp.tok", 32'(tok_count), 32'd6);

        redir(32'd8);
        step(); out("rd0", 32'hE3A01005, 32'd8, 2'd0);
        step(); out("rd1", 32'hE0811001, 32'd8, 2'd1);
        redir(32'd40);
        check("rd.tok", 32'(tok_count), 32'd8);
        step(); out("rd.tgt", 32'hE3A0202A, 32'd40, 2'd0);

        redir(32'd16);
        wme = 1'b1;
        wr_idx = 7'd5;
        wr_data = 32'hDEADBEEF;
        step();
        wme = 1'b0;
        out("hz.old", 32'hE3A01005, 32'd16, 2'd0);
        check("hz.tok", 32'(tok_count), 32'd9);
        redir(32'd16);
        step(); out("hz.new", 32'hDEADBEEF, 32'd16, 2'd0);

        redir(32'd24);
        check("fe.pre", 32'(fmt_err), 32'd0);
        step(); out("fe0", 32'hDEADBEEF, 32'd24, 2'd0);
        check("fe.set", 32'(fmt_err), 32'd1);
        step(); out("fe1", 32'hE0811001, 32'd24, 2'd1);
        step(); out("fe2", 32'hE5801000, 32'd24, 2'd2);
        check("fe.pc", bus.imem_addr, 32'd28);
        check("fe.tok", 32'(tok_count), 32'd13);
        step(); out("fe.next", 32'hE1A00000, 32'd28, 2'd0);
        check("fe.sticky", 32'(fmt_err), 32'd1);

        redir(32'd24);
        step(); out("rx0", 32'hDEADBEEF, 32'd24, 2'd0);
        step(); out("rx1", 32'hE0811001, 32'd24, 2'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rx.valid", 32'(bus.instr_valid), 32'd0);
        check("rx.instr", bus.instr, 32'd0);
        check("rx.pc", bus.imem_addr, 32'd0);
        check("rx.fmt", 32'(fmt_err), 32'd0);
        check("rx.tok", 32'(tok_count), 32'd0);
        step(); out("rx.raw", 32'hE3A00001, 32'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
